// File: rtl/nn_dense_layer.sv
// Fully-connected layer: NOUT neurons x NIN signed fixed-point inputs on one time-shared MAC.
// Build option NN_SAT_EN: saturate results and flag ovf; otherwise results wrap and ovf reads 0.
//
// state | meaning
// IDLE  | waiting for start; parameter writes accepted
// LOAD  | latch input vector, clear accumulator and counters
// MAC   | one product per cycle for the current neuron
// FIN   | add bias, rescale, fit, activate; advance neuron or finish
module nn_dense_layer #(
    parameter int NIN  = 4,
    parameter int NOUT = 4,
    parameter int W    = 16,
    parameter int FRAC = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic                                relu_en,
    input  logic [NIN*W-1:0]                    in,
    input  logic                                wr_en,
    input  logic [$clog2(NOUT*(NIN+1))-1:0]     wr_addr,
    input  logic [W-1:0]                        wr_data,
    output logic [NOUT*W-1:0]                   out,
    output logic                                busy,
    output logic                                done,
    output logic                                wr_err,
    output logic                                ovf
);

    localparam int NP   = NOUT * (NIN + 1);
    localparam int AW   = $clog2(NP);
    localparam int ACCW = 2 * W + $clog2(NIN) + 1;
    localparam int CW   = (NIN > 1) ? $clog2(NIN) : 1;
    localparam int JW   = (NOUT > 1) ? $clog2(NOUT) : 1;
    localparam logic [AW:0]   NP_L     = (AW + 1)'(NP);
    localparam logic [CW-1:0] CNT_LAST = CW'(NIN - 1);
    localparam logic [JW-1:0] J_LAST   = JW'(NOUT - 1);

    typedef enum logic [1:0] {IDLE, LOAD, MAC, FIN} state_t;

    state_t                  state;
    logic signed [W-1:0]     params [NP];
    logic [NIN*W-1:0]        x_sh;
    logic signed [ACCW-1:0]  acc;
    logic [AW-1:0]           ptr;
    logic [CW-1:0]           mac_cnt;
    logic [JW-1:0]           j;
    logic                    relu_q;
    logic [NOUT*W-1:0]       shadow;
    logic [NOUT*W-1:0]       shadow_nxt;
    logic signed [2*W-1:0]   prod;
    logic signed [ACCW-1:0]  sum;
    logic signed [W-1:0]     res_fit;
    logic signed [W-1:0]     res_act;

    // Parameters are stored linearly as w[j][0..NIN-1], b[j], so one pointer walks the whole evaluation.
    assign prod = $signed(x_sh[W-1:0]) * params[ptr];
    assign sum  = acc + (ACCW'(params[ptr]) <<< FRAC);

`ifdef NN_SAT_EN
    logic signed [ACCW-1:0] shifted;
    logic [ACCW-W:0]        hi;
    logic                   clip;

    assign shifted = sum >>> FRAC;
    assign hi      = shifted[ACCW-1:W-1];
    assign clip    = !((&hi) || !(|hi));
    assign res_fit = !clip ? shifted[W-1:0] :
                     shifted[ACCW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf <= 1'b0;
        end else if (state == IDLE && start) begin
            ovf <= 1'b0;
        end else if (state == FIN && clip) begin
            ovf <= 1'b1;
        end
    end
`else
    assign res_fit = W'(sum >>> FRAC);
    assign ovf     = 1'b0;
`endif

    assign res_act = (relu_q && res_fit[W-1]) ? '0 : res_fit;

    always_comb begin
        shadow_nxt = shadow;
        shadow_nxt[j*W +: W] = res_act;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            out     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            wr_err  <= 1'b0;
            x_sh    <= '0;
            acc     <= '0;
            ptr     <= '0;
            mac_cnt <= '0;
            j       <= '0;
            relu_q  <= 1'b0;
            shadow  <= '0;
            for (int k = 0; k < NP; k++) begin
                params[k] <= '0;
            end
        end else begin
            done   <= 1'b0;
            wr_err <= 1'b0;

            if (wr_en) begin
                if (state != IDLE || {1'b0, wr_addr} >= NP_L) begin
                    wr_err <= 1'b1;
                end else begin
                    params[wr_addr] <= wr_data;
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= LOAD;
                        busy   <= 1'b1;
                        relu_q <= relu_en;
                    end
                end
                LOAD: begin
                    x_sh    <= in;
                    acc     <= '0;
                    ptr     <= '0;
                    j       <= '0;
                    mac_cnt <= CNT_LAST;
                    state   <= MAC;
                end
                MAC: begin
                    acc  <= acc + ACCW'(prod);
                    // Rotating the input vector brings x[0] back into place for the next neuron.
                    x_sh <= {x_sh[W-1:0], x_sh[NIN*W-1:W]};
                    ptr  <= ptr + 1'b1;
                    if (mac_cnt == '0) begin
                        state <= FIN;
                    end else begin
                        mac_cnt <= mac_cnt - 1'b1;
                    end
                end
                FIN: begin
                    shadow  <= shadow_nxt;
                    acc     <= '0;
                    mac_cnt <= CNT_LAST;
                    if (j == J_LAST) begin
                        out   <= shadow_nxt;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        ptr   <= '0;
                        state <= IDLE;
                    end else begin
                        j     <= j + 1'b1;
                        ptr   <= ptr + 1'b1;
                        state <= MAC;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nn_dense_layer.sv
// Directed bench for nn_dense_layer at W=16, FRAC=8, NIN=NOUT=4.
module tb_nn_dense_layer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        relu_en;
    logic [63:0] in_v;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;
    logic [63:0] out_v;
    logic        busy;
    logic        done;
    logic        wr_err;
    logic        ovf;

    int checks   = 0;
    int failures = 0;

    localparam logic [63:0] ID_IN   = {16'h0080, 16'hFD00, 16'h0200, 16'h0100};
    localparam logic [63:0] ID_RELU = {16'h0080, 16'h0000, 16'h0200, 16'h0100};
    localparam logic [63:0] BIAS_OUT = {16'h0300, 16'h0200, 16'h0100, 16'h0000};

    nn_dense_layer #(.NIN(4), .NOUT(4), .W(16), .FRAC(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .relu_en (relu_en),
        .in      (in_v),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .out     (out_v),
        .busy    (busy),
        .done    (done),
        .wr_err  (wr_err),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wr(input int addr, input logic [15:0] d);
        wr_en   = 1'b1;
        wr_addr = addr[4:0];
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic load_params(input logic [15:0] wdiag, input logic [15:0] woff, input logic [15:0] bstep);
        for (int jj = 0; jj < 4; jj++) begin
            for (int ii = 0; ii < 4; ii++) begin
                wr(jj * 5 + ii, (ii == jj) ? wdiag : woff);
            end
            wr(jj * 5 + 4, bstep * 16'(jj));
        end
    endtask

    // Starts an evaluation at the current negedge; optionally pulses a stray write+start at cycle inj_k.
    task automatic run_eval(input logic relu, input int inj_k, output int lat, output int bc,
                            output logic err_seen);
        start    = 1'b1;
        relu_en  = relu;
        lat      = -1;
        bc       = 0;
        err_seen = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start = 1'b0;
            wr_en = 1'b0;
            if (k == inj_k + 1 && wr_err) err_seen = 1'b1;
            if (busy) bc++;
            if (done) begin
                lat = k;
                break;
            end
            if (k == inj_k) begin
                wr_en   = 1'b1;
                wr_addr = 5'd0;
                wr_data = 16'h0200;
                start   = 1'b1;
            end
        end
    endtask

    task automatic test_reset;
        checks++; if (out_v !== 64'h0) begin failures++; $display("FAIL reset_out got=%h exp=0", out_v); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (wr_err !== 1'b0) begin failures++; $display("FAIL reset_wr_err got=%b exp=0", wr_err); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    endtask

    task automatic test_wr_addr;
        wr(25, 16'h1234);
        checks++; if (wr_err !== 1'b1) begin failures++; $display("FAIL bad_addr_err got=%b exp=1", wr_err); end
        @(negedge clk);
        checks++; if (wr_err !== 1'b0) begin failures++; $display("FAIL err_pulse_width got=%b exp=0", wr_err); end
        wr(19, 16'h0000);
        checks++; if (wr_err !== 1'b0) begin failures++; $display("FAIL good_addr_err got=%b exp=0", wr_err); end
    endtask

    task automatic test_identity;
        int lat, bc;
        logic es;
        load_params(16'h0100, 16'h0000, 16'h0000);
        in_v = ID_IN;
        run_eval(1'b0, -5, lat, bc, es);
        checks++; if (lat != 22) begin failures++; $display("FAIL id_latency got=%0d exp=22", lat); end
        checks++; if (bc != 21) begin failures++; $display("FAIL id_busy_cycles got=%0d exp=21", bc); end
        checks++; if (out_v !== ID_IN) begin failures++; $display("FAIL id_out got=%h exp=%h", out_v, ID_IN); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL id_ovf got=%b exp=0", ovf); end
        repeat (3) @(negedge clk);
        checks++; if (out_v !== ID_IN) begin failures++; $display("FAIL id_out_hold got=%h exp=%h", out_v, ID_IN); end
    endtask

    task automatic test_relu;
        int lat, bc;
        logic es;
        run_eval(1'b1, -5, lat, bc, es);
        checks++; if (lat != 22) begin failures++; $display("FAIL relu_latency got=%0d exp=22", lat); end
        checks++; if (out_v !== ID_RELU) begin failures++; $display("FAIL relu_out got=%h exp=%h", out_v, ID_RELU); end
    endtask

    task automatic test_write_with_start;
        int lat, bc;
        logic es;
        logic [63:0] exp_v;
        exp_v = {16'h0080, 16'hFD00, 16'h0200, 16'h0200};
        wr_en   = 1'b1;
        wr_addr = 5'd0;
        wr_data = 16'h0200;
        run_eval(1'b0, -5, lat, bc, es);
        checks++; if (out_v !== exp_v) begin failures++; $display("FAIL wr_start_out got=%h exp=%h", out_v, exp_v); end
        wr(0, 16'h0100);
    endtask

    task automatic test_midrun;
        int lat, bc, ndone;
        logic es;
        run_eval(1'b0, 5, lat, bc, es);
        checks++; if (es !== 1'b1) begin failures++; $display("FAIL mid_wr_err got=%b exp=1", es); end
        checks++; if (lat != 22) begin failures++; $display("FAIL mid_latency got=%0d exp=22", lat); end
        checks++; if (out_v !== ID_IN) begin failures++; $display("FAIL mid_out got=%h exp=%h", out_v, ID_IN); end
        ndone = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        checks++; if (ndone != 0) begin failures++; $display("FAIL mid_extra_done got=%0d exp=0", ndone); end
        run_eval(1'b0, -5, lat, bc, es);
        checks++; if (out_v !== ID_IN) begin failures++; $display("FAIL mid_param_kept got=%h exp=%h", out_v, ID_IN); end
    endtask

    task automatic test_back_to_back;
        int lat, bc;
        logic es;
        load_params(16'h0000, 16'h0000, 16'h0100);
        run_eval(1'b0, -5, lat, bc, es);
        checks++; if (out_v !== BIAS_OUT) begin failures++; $display("FAIL bias_out got=%h exp=%h", out_v, BIAS_OUT); end
        run_eval(1'b0, -5, lat, bc, es);
        checks++; if (lat != 22) begin failures++; $display("FAIL b2b_latency got=%0d exp=22", lat); end
        checks++; if (out_v !== BIAS_OUT) begin failures++; $display("FAIL b2b_out got=%h exp=%h", out_v, BIAS_OUT); end
    endtask

    task automatic test_saturation;
        int lat, bc;
        logic es;
        logic [63:0] exp_v;
        logic        exp_o;
`ifdef NN_SAT_EN
        exp_v = {4{16'h7FFF}};
        exp_o = 1'b1;
`else
        exp_v = {4{16'hFC00}};
        exp_o = 1'b0;
`endif
        load_params(16'h7FFF, 16'h7FFF, 16'h0000);
        in_v = {4{16'h7FFF}};
        run_eval(1'b0, -5, lat, bc, es);
        checks++; if (out_v !== exp_v) begin failures++; $display("FAIL sat_out got=%h exp=%h", out_v, exp_v); end
        checks++; if (ovf !== exp_o) begin failures++; $display("FAIL sat_ovf got=%b exp=%b", ovf, exp_o); end
        repeat (4) @(negedge clk);
        checks++; if (ovf !== exp_o) begin failures++; $display("FAIL sat_ovf_sticky got=%b exp=%b", ovf, exp_o); end
        load_params(16'h0000, 16'h0000, 16'h0100);
        run_eval(1'b0, -5, lat, bc, es);
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL ovf_cleared got=%b exp=0", ovf); end
        checks++; if (out_v !== BIAS_OUT) begin failures++; $display("FAIL post_sat_out got=%h exp=%h", out_v, BIAS_OUT); end
    endtask

    task automatic test_reset_mid;
        int lat, bc, ndone;
        logic es;
        start   = 1'b1;
        relu_en = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rmid_busy_before got=%b exp=1", busy); end
        rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", busy); end
        checks++; if (out_v !== 64'h0) begin failures++; $display("FAIL rmid_out got=%h exp=0", out_v); end
        checks++; if (done !== 1'b0 || ovf !== 1'b0) begin
            failures++; $display("FAIL rmid_done_ovf got=%b%b exp=00", done, ovf);
        end
        @(negedge clk);
        rst = 1'b1;
        ndone = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        checks++; if (ndone != 0) begin failures++; $display("FAIL rmid_no_done got=%0d exp=0", ndone); end
        in_v = ID_IN;
        run_eval(1'b0, -5, lat, bc, es);
        checks++; if (lat != 22) begin failures++; $display("FAIL rmid_latency got=%0d exp=22", lat); end
        checks++; if (out_v !== 64'h0) begin failures++; $display("FAIL rmid_params_cleared got=%h exp=0", out_v); end
    endtask

    initial begin
        rst     = 1'b0;
        start   = 1'b0;
        relu_en = 1'b0;
        in_v    = '0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        test_reset;
        test_wr_addr;
        test_identity;
        test_relu;
        test_write_with_start;
        test_midrun;
        test_back_to_back;
        test_saturation;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=timeout exp=finish");
        $fatal(1, "time limit");
    end

endmodule
